// File: rtl/masked_ctrl_pkg.sv
// rtl/masked_ctrl_pkg.sv - shared types and constants for the masked AND scheduler
package masked_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  // Enabled edges the gadget needs per evaluation.
  localparam int GADGET_LAT = 3;
  // Upper bound on enabled cycles spent re-aligning the gadget counter.
  localparam int SYNC_MAX   = 4;

  // Fresh randomness bits consumed by one d-share AND evaluation.
  function automatic int rand_w(input int d);
    return d * (d - 1) / 2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered priority pointer
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_q;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    int            j;
    logic          found;
    logic [IW-1:0] jj;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

  // After a grant the winner drops to lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/masked_and_sched.sv
// rtl/masked_and_sched.sv - round-robin sharing of one 2-share masked AND gadget
module masked_and_sched
  import masked_ctrl_pkg::*;
#(
  parameter int D     = 2,
  parameter int N_REQ = 4,
  localparam int RAND_W = rand_w(D),
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*D-1:0]   a_sh,
  input  logic [N_REQ*D-1:0]   b_sh,
  output logic [N_REQ-1:0]     gnt,
  input  logic [RAND_W-1:0]    rand_in,
  input  logic                 rand_valid,
  output logic                 rand_ready,
  output logic                 and_en,
  output logic [D-1:0]         and_ina,
  output logic [D-1:0]         and_inb,
  output logic [RAND_W-1:0]    and_rin,
  input  logic [D-1:0]         and_out,
  input  logic                 and_done,
  output logic                 resp_valid,
  output logic [IW-1:0]        resp_id,
  output logic [D-1:0]         resp_sh,
  output logic                 busy,
  output logic                 err
);

  state_e            state_q;
  logic [1:0]        run_cnt_q;
  logic [2:0]        sync_cnt_q;
  logic [IW-1:0]     win_q;
  logic [D-1:0]      and_ina_q;
  logic [D-1:0]      and_inb_q;
  logic [RAND_W-1:0] and_rin_q;
  logic              resp_valid_q;
  logic [IW-1:0]     resp_id_q;
  logic [D-1:0]      resp_sh_q;
  logic              err_q;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              accept;
  logic              sync_exit;

  // A grant needs a requester and a randomness word in the same IDLE cycle.
  assign accept     = (state_q == ST_IDLE) && (|req) && rand_valid;
  assign gnt        = accept ? arb_gnt : '0;
  assign rand_ready = |gnt;
  assign busy       = (state_q != ST_IDLE);

  // A done flag on the very first SYNC cycle may be stale, so it only counts later.
  assign sync_exit  = and_done && (sync_cnt_q != 3'd0);

  assign and_ina    = and_ina_q;
  assign and_inb    = and_inb_q;
  assign and_rin    = and_rin_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sh    = resp_sh_q;
  assign err        = err_q;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (accept),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  // Gadget enable: whole RUN window, and every SYNC cycle except the exit cycle.
  always_comb begin
    and_en = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN:  and_en = 1'b1;
        ST_SYNC: and_en = !sync_exit;
        default: and_en = 1'b0;
      endcase
    end
  end

  // Control FSM: latch operands, time the gadget window, check done, re-align.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      run_cnt_q    <= '0;
      sync_cnt_q   <= '0;
      win_q        <= '0;
      and_ina_q    <= '0;
      and_inb_q    <= '0;
      and_rin_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sh_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            and_ina_q <= a_sh[arb_idx*D +: D];
            and_inb_q <= b_sh[arb_idx*D +: D];
            and_rin_q <= rand_in;
            win_q     <= arb_idx;
            run_cnt_q <= '0;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (run_cnt_q == 2'(GADGET_LAT - 1)) begin
            state_q <= ST_CHECK;
          end else begin
            run_cnt_q <= run_cnt_q + 2'd1;
          end
        end
        ST_CHECK: begin
          if (and_done) begin
            resp_sh_q    <= and_out;
            resp_id_q    <= win_q;
            resp_valid_q <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            err_q      <= 1'b1;
            sync_cnt_q <= '0;
            state_q    <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (sync_exit) begin
            sync_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end else if (sync_cnt_q == 3'(SYNC_MAX - 1)) begin
            err_q      <= 1'b1;
            sync_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end else begin
            sync_cnt_q <= sync_cnt_q + 3'd1;
          end
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_masked_and_sched.sv
// tb/tb_masked_and_sched.sv - self-checking bench for masked_and_sched
module tb_masked_and_sched;
  localparam int D = 2;
  localparam int N = 4;
  localparam int W = N * D;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [W-1:0]  a_sh, b_sh;
  logic [N-1:0]  gnt;
  logic          rand_in, rand_valid, rand_ready;
  logic          and_en;
  logic [D-1:0]  and_ina, and_inb;
  logic          and_rin;
  logic [D-1:0]  and_out;
  logic          and_done;
  logic          resp_valid;
  logic [1:0]    resp_id;
  logic [D-1:0]  resp_sh;
  logic          busy, err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Gadget model: free-running counter with no reset, done on every 3rd enabled edge.
  logic [1:0]   g_cnt;
  logic         g_done;
  logic [D-1:0] g_out;
  logic         g_load;
  logic [1:0]   g_load_val;
  logic         g_dead;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (g_load) begin
      g_cnt  <= g_load_val;
      g_done <= 1'b0;
    end else if (and_en) begin
      if (g_cnt == 2'd2) begin
        g_cnt  <= 2'd0;
        g_done <= 1'b1;
        g_out  <= {(and_ina[1] & and_inb[1]) ^ and_rin ^ (and_ina[1] & and_inb[0]),
                   (and_ina[0] & and_inb[0]) ^ and_rin ^ (and_ina[0] & and_inb[1])};
      end else begin
        g_cnt  <= g_cnt + 2'd1;
        g_done <= 1'b0;
      end
    end
  end

  assign and_done = g_done & ~g_dead;
  assign and_out  = g_out;

  masked_and_sched #(.D(D), .N_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_sh       (a_sh),
    .b_sh       (b_sh),
    .gnt        (gnt),
    .rand_in    (rand_in),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .and_en     (and_en),
    .and_ina    (and_ina),
    .and_inb    (and_inb),
    .and_rin    (and_rin),
    .and_out    (and_out),
    .and_done   (and_done),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sh    (resp_sh),
    .busy       (busy),
    .err        (err)
  );

  task automatic nxt();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input logic [1:0] pv);
    nxt();
    rst = 1'b1; g_load = 1'b1; g_load_val = pv; g_dead = 1'b0;
    req = '0; rand_valid = 1'b0;
    nxt();
    nxt();
    rst = 1'b0; g_load = 1'b0;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (!busy) break;
      nxt();
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sync_timeout busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    int   en_cnt;
    logic ended;
    nxt();
    rst = 1'b1; g_load = 1'b1; g_load_val = 2'd1;
    req = 4'b1111; rand_valid = 1'b1;
    #1;
    n_cmp++; if (and_en !== 1'b0)     begin n_fail++; $display("FAIL rst_and_en got=%b req=0", and_en); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%b req=0", resp_valid); end
    n_cmp++; if (err !== 1'b0)        begin n_fail++; $display("FAIL rst_err got=%b req=0", err); end
    n_cmp++; if ({and_ina, and_inb, and_rin} !== 5'd0) begin n_fail++; $display("FAIL rst_gadget_in got=%b req=0", {and_ina, and_inb, and_rin}); end
    n_cmp++; if ({resp_id, resp_sh} !== 4'd0) begin n_fail++; $display("FAIL rst_resp got=%b req=0", {resp_id, resp_sh}); end
    n_cmp++; if (gnt !== 4'b0000 || rand_ready !== 1'b0) begin n_fail++; $display("FAIL rst_gnt got=%b/%b req=0000/0", gnt, rand_ready); end
    n_cmp++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL rst_busy got=%b req=1", busy); end
    nxt();
    nxt();
    rst = 1'b0; g_load = 1'b0; req = '0; rand_valid = 1'b0;
    #1;
    en_cnt = 0; ended = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!busy) begin ended = 1'b1; break; end
      if (and_en) en_cnt++;
      nxt();
      #1;
    end
    n_cmp++; if (ended !== 1'b1) begin n_fail++; $display("FAIL sync_end got=%b req=1", ended); end
    n_cmp++; if (en_cnt != 2)    begin n_fail++; $display("FAIL sync_en_cycles got=%0d req=2", en_cnt); end
    n_cmp++; if (err !== 1'b0)   begin n_fail++; $display("FAIL sync_err got=%b req=0", err); end
    n_cmp++; if (g_cnt !== 2'd0) begin n_fail++; $display("FAIL sync_align gadget_cnt=%0d req=0", g_cnt); end
  endtask

  task automatic test_single();
    nxt();
    a_sh = W'($urandom); b_sh = W'($urandom);
    a_sh[5:4] = 2'b10; b_sh[5:4] = 2'b01;
    req = 4'b0100; rand_in = 1'b1; rand_valid = 1'b1;
    #1;
    n_cmp++; if (gnt !== 4'b0100 || rand_ready !== 1'b1) begin n_fail++; $display("FAIL single_gnt got=%b/%b req=0100/1", gnt, rand_ready); end
    for (int k = 1; k <= 6; k++) begin
      nxt();
      req = '0; a_sh = W'($urandom); b_sh = W'($urandom);
      rand_in = 1'($urandom); rand_valid = 1'($urandom);
      #1;
      n_cmp++; if (and_en !== (k <= 3)) begin n_fail++; $display("FAIL single_en k=%0d got=%b req=%b", k, and_en, (k <= 3)); end
      n_cmp++; if (resp_valid !== (k == 5)) begin n_fail++; $display("FAIL single_rv k=%0d got=%b req=%b", k, resp_valid, (k == 5)); end
      if (k == 2) begin
        n_cmp++; if ({and_ina, and_inb, and_rin} !== 5'b10011) begin n_fail++; $display("FAIL single_latch got=%b req=10011", {and_ina, and_inb, and_rin}); end
      end
      if (k == 5) begin
        n_cmp++; if (resp_id !== 2'd2)  begin n_fail++; $display("FAIL single_id got=%0d req=2", resp_id); end
        n_cmp++; if ((^resp_sh) !== 1'b1) begin n_fail++; $display("FAIL single_xor got=%b req=1", ^resp_sh); end
      end
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] r;
    logic [N-1:0] eg;
    do_reset(2'd0);
    r = 4'b1111;
    a_sh = W'($urandom); b_sh = W'($urandom);
    for (int k = 0; k <= 20; k++) begin
      nxt();
      if (k == 16) r[1:0] = 2'b11;
      req = r; rand_valid = 1'b1; rand_in = 1'($urandom);
      #1;
      case (k)
        0:       eg = 4'b0001;
        5:       eg = 4'b0010;
        10:      eg = 4'b0100;
        15:      eg = 4'b1000;
        20:      eg = 4'b0001;
        default: eg = 4'b0000;
      endcase
      n_cmp++; if (gnt !== eg) begin n_fail++; $display("FAIL cont_gnt k=%0d got=%b req=%b", k, gnt, eg); end
      if (k != 0 && (k % 5) == 0) begin
        n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 2'(k / 5 - 1)) begin n_fail++; $display("FAIL cont_resp k=%0d got=%b/%0d req=1/%0d", k, resp_valid, resp_id, k / 5 - 1); end
      end
      r = r & ~eg;
    end
    req = '0;
    for (int k = 0; k < 5; k++) nxt();
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 3; k++) begin
      nxt();
      req = 4'b0001; rand_valid = 1'b0;
      #1;
      n_cmp++; if (gnt !== 4'b0000 || rand_ready !== 1'b0 || and_en !== 1'b0) begin n_fail++; $display("FAIL starve k=%0d gnt/rdy/en=%b/%b/%b req=0000/0/0", k, gnt, rand_ready, and_en); end
    end
    nxt();
    rand_valid = 1'b1;
    #1;
    n_cmp++; if (gnt !== 4'b0001 || rand_ready !== 1'b1) begin n_fail++; $display("FAIL starve_release gnt/rdy=%b/%b req=0001/1", gnt, rand_ready); end
    nxt();
    req = '0;
    for (int k = 0; k < 4; k++) nxt();
  endtask

  task automatic test_dead_gadget();
    int   en_cnt;
    logic seen;
    nxt();
    g_dead = 1'b1; req = 4'b0010; rand_valid = 1'b1;
    a_sh = W'($urandom); b_sh = W'($urandom);
    #1;
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL dead_gnt got=%b req=0010", gnt); end
    en_cnt = 0; seen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      nxt();
      req = '0;
      #1;
      if (resp_valid) seen = 1'b1;
      if (k >= 5 && and_en) en_cnt++;
      if (k == 4) begin
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL dead_err_early got=%b req=0", err); end
      end
      if (k == 5) begin
        n_cmp++; if (err !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL dead_err err/busy=%b/%b req=1/1", err, busy); end
      end
      if (k == 9) begin
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dead_sync_timeout busy=%b req=0", busy); end
      end
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL dead_resp got=%b req=0", seen); end
    n_cmp++; if (en_cnt != 4)   begin n_fail++; $display("FAIL dead_sync_en got=%0d req=4", en_cnt); end
    g_dead = 1'b0;
    for (int k = 0; k < 3; k++) nxt();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL dead_err_sticky got=%b req=1", err); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    int   w;
    do_reset(2'd0);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%b req=0", err); end
    nxt();
    req = 4'b1000; rand_valid = 1'b1;
    a_sh = W'($urandom); b_sh = W'($urandom);
    #1;
    n_cmp++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL mid_gnt got=%b req=1000", gnt); end
    nxt();
    req = '0;
    nxt();
    rst = 1'b1;
    #1;
    n_cmp++; if (and_en !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst en/rv=%b/%b req=0/0", and_en, resp_valid); end
    nxt();
    rst = 1'b0;
    #1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (resp_valid) seen = 1'b1;
      if (!busy) break;
      nxt();
      #1;
    end
    n_cmp++; if (seen !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_sync rv_seen/busy=%b/%b req=0/0", seen, busy); end
    n_cmp++; if (g_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_align gadget_cnt=%0d req=0", g_cnt); end
    w = $urandom_range(0, N - 1);
    nxt();
    req = '0; req[w] = 1'b1; rand_valid = 1'b1; rand_in = 1'($urandom);
    a_sh = W'($urandom); b_sh = W'($urandom);
    a_sh[w*D +: D] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    b_sh[w*D +: D] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    #1;
    n_cmp++; if (gnt !== (4'b0001 << w)) begin n_fail++; $display("FAIL mid_op_gnt got=%b req=%b", gnt, 4'b0001 << w); end
    nxt();
    req = '0;
    for (int k = 2; k <= 5; k++) nxt();
    #1;
    n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 2'(w) || (^resp_sh) !== 1'b1) begin
      n_fail++; $display("FAIL mid_op_resp rv/id/xor=%b/%0d/%b req=1/%0d/1", resp_valid, resp_id, ^resp_sh, w);
    end
  endtask

  task automatic test_random();
    logic         pend [N];
    logic [D-1:0] pa [N];
    logic [D-1:0] pb [N];
    logic [N-1:0] eg;
    int           ptr, acc, w, e_id;
    logic         e_x, have, e_en, e_busy, e_rv;
    do_reset(2'($urandom_range(0, 2)));
    ptr = 0; acc = cyc - 10; have = 1'b0; e_id = 0; e_x = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
    for (int t = 0; t < 400; t++) begin
      nxt();
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1; pa[i] = D'($urandom); pb[i] = D'($urandom);
        end
      end
      a_sh = W'($urandom); b_sh = W'($urandom);
      for (int i = 0; i < N; i++) begin
        req[i] = pend[i];
        if (pend[i]) begin a_sh[i*D +: D] = pa[i]; b_sh[i*D +: D] = pb[i]; end
      end
      rand_valid = ($urandom_range(0, 3) != 0);
      rand_in = 1'($urandom);
      #1;
      eg = '0; w = -1;
      if (cyc >= acc + 5 && rand_valid) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (ptr + k) % N;
          if (w < 0 && pend[j]) w = j;
        end
      end
      if (w >= 0) eg[w] = 1'b1;
      e_en   = (cyc > acc && cyc <= acc + 3);
      e_busy = (cyc > acc && cyc < acc + 5);
      e_rv   = have && (cyc == acc + 5);
      n_cmp++; if (gnt !== eg)            begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b req=%b", cyc, gnt, eg); end
      n_cmp++; if (rand_ready !== (|eg))  begin n_fail++; $display("FAIL rnd_rdy cyc=%0d got=%b req=%b", cyc, rand_ready, |eg); end
      n_cmp++; if (and_en !== e_en)       begin n_fail++; $display("FAIL rnd_en cyc=%0d got=%b req=%b", cyc, and_en, e_en); end
      n_cmp++; if (busy !== e_busy)       begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b req=%b", cyc, busy, e_busy); end
      n_cmp++; if (resp_valid !== e_rv)   begin n_fail++; $display("FAIL rnd_rv cyc=%0d got=%b req=%b", cyc, resp_valid, e_rv); end
      if (e_rv) begin
        n_cmp++; if (resp_id !== 2'(e_id) || (^resp_sh) !== e_x) begin
          n_fail++; $display("FAIL rnd_resp cyc=%0d id/xor=%0d/%b req=%0d/%b", cyc, resp_id, ^resp_sh, e_id, e_x);
        end
      end
      if (w >= 0) begin
        acc = cyc; e_id = w; e_x = (^pa[w]) & (^pb[w]); have = 1'b1;
        pend[w] = 1'b0; ptr = (w + 1) % N;
      end
    end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rnd_err got=%b req=0", err); end
    req = '0;
    for (int k = 0; k < 6; k++) nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; g_load = 1'b1; g_load_val = 2'd1; g_dead = 1'b0;
    req = '0; a_sh = '0; b_sh = '0; rand_in = 1'b0; rand_valid = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_starvation();
    test_dead_gadget();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
